// File: rtl/purisc_pkg.sv
// Shared definitions for the PURISC compute group: bus widths and the
// SUBLEQ core's instruction-phase encoding.
package purisc_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FETCH_AB = 2'd0,
    FETCH_C  = 2'd1,
    READ     = 2'd2,
    WRITE    = 2'd3
  } cpu_state_t;

endpackage

// File: rtl/subleq_cpu.sv
// SUBLEQ core: M[B] <= M[B] - M[A]; branch to C when the result is <= 0.
// Each instruction takes four granted cycles on a shared dual-port RAM.
module subleq_cpu
  import purisc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_local_id,
  output logic [ADDR_W-1:0] c_ram_addr_a,
  output logic [ADDR_W-1:0] c_ram_addr_b,
  input  logic [DATA_W-1:0] ram_c_data_a,
  input  logic [DATA_W-1:0] ram_c_data_b,
  input  logic              ram_c_en,
  output logic              c_ram_we_b,
  output logic [DATA_W-1:0] c_ram_data_b
);

  localparam logic [1:0] ST_FETCH_AB = FETCH_AB;
  localparam logic [1:0] ST_FETCH_C  = FETCH_C;
  localparam logic [1:0] ST_READ     = READ;
  localparam logic [1:0] ST_WRITE    = WRITE;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] rc;
  logic [DATA_W-1:0] diff;

  logic [ADDR_W-1:0] pc_inc1;
  logic [ADDR_W-1:0] pc_inc2;
  logic [ADDR_W-1:0] pc_inc3;
  logic              take_branch;

  // Address arithmetic wraps naturally at 17 bits.
  assign pc_inc1     = pc + 17'd1;
  assign pc_inc2     = pc + 17'd2;
  assign pc_inc3     = pc + 17'd3;
  assign take_branch = diff[31] | (diff == 32'd0);

  // Instruction sequencer: advances only on cycles the arbiter grants us.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FETCH_AB;
      pc    <= {cpu_local_id, 16'h0000};
      ra    <= 17'd0;
      rb    <= 17'd0;
      rc    <= 17'd0;
      diff  <= 32'd0;
    end else if (ram_c_en) begin
      case (state)
        ST_FETCH_AB: begin
          ra    <= ram_c_data_a[ADDR_W-1:0];
          rb    <= ram_c_data_b[ADDR_W-1:0];
          state <= ST_FETCH_C;
        end
        ST_FETCH_C: begin
          rc    <= ram_c_data_a[ADDR_W-1:0];
          state <= ST_READ;
        end
        ST_READ: begin
          diff  <= ram_c_data_b - ram_c_data_a;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          pc    <= take_branch ? rc : pc_inc3;
          state <= ST_FETCH_AB;
        end
        default: begin
          state <= ST_FETCH_AB;
        end
      endcase
    end
  end

  // RAM-side outputs depend only on registers, so they hold steady while stalled.
  always_comb begin
    c_ram_addr_a = pc;
    c_ram_addr_b = pc_inc1;
    c_ram_we_b   = 1'b0;
    case (state)
      ST_FETCH_AB: begin
        c_ram_addr_a = pc;
        c_ram_addr_b = pc_inc1;
      end
      ST_FETCH_C: begin
        c_ram_addr_a = pc_inc2;
        c_ram_addr_b = pc_inc1;
      end
      ST_READ: begin
        c_ram_addr_a = ra;
        c_ram_addr_b = rb;
      end
      ST_WRITE: begin
        c_ram_addr_a = ra;
        c_ram_addr_b = rb;
        c_ram_we_b   = 1'b1;
      end
      default: begin
        c_ram_addr_a = pc;
        c_ram_addr_b = pc_inc1;
      end
    endcase
  end

  assign c_ram_data_b = diff;

endmodule

// File: tb/tb_subleq_cpu.sv
// Directed bench for subleq_cpu: two cores on one modelled dual-port RAM,
// with the bench acting as arbiter.
module tb_subleq_cpu;

  logic        clock = 1'b0;
  logic        reset;
  logic        en0;
  logic        en1;
  logic [16:0] a0, b0, a1, b1;
  logic        we0, we1;
  logic [31:0] wd0, wd1;
  logic [16:0] ram_a, ram_b;
  logic [31:0] rd_a, rd_b;
  logic [31:0] mem [0:131071];
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  // Same-cycle read; address mux follows whichever core holds the grant.
  assign ram_a = en1 ? a1 : a0;
  assign ram_b = en1 ? b1 : b0;
  assign rd_a  = mem[ram_a];
  assign rd_b  = mem[ram_b];

  subleq_cpu u0 (
    .clock(clock), .reset(reset), .cpu_local_id(1'b0),
    .c_ram_addr_a(a0), .c_ram_addr_b(b0),
    .ram_c_data_a(rd_a), .ram_c_data_b(rd_b), .ram_c_en(en0),
    .c_ram_we_b(we0), .c_ram_data_b(wd0)
  );

  subleq_cpu u1 (
    .clock(clock), .reset(reset), .cpu_local_id(1'b1),
    .c_ram_addr_a(a1), .c_ram_addr_b(b1),
    .ram_c_data_a(rd_a), .ram_c_data_b(rd_b), .ram_c_en(en1),
    .c_ram_we_b(we1), .c_ram_data_b(wd1)
  );

  // One clock: grants applied, RAM write committed just after the edge.
  task automatic do_cycle(input logic g0, input logic g1);
    logic        wr;
    logic [16:0] wa;
    logic [31:0] wdat;
    en0  = g0;
    en1  = g1;
    wr   = 1'b0;
    wa   = 17'd0;
    wdat = 32'd0;
    if (g0 && we0) begin
      wr = 1'b1; wa = b0; wdat = wd0;
    end else if (g1 && we1) begin
      wr = 1'b1; wa = b1; wdat = wd1;
    end
    @(posedge clock);
    #1;
    if (wr) mem[wa] = wdat;
    en0 = 1'b0;
    en1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    do_cycle(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Runs one instruction on a core, with `stall` ungranted cycles before each grant.
  task automatic exp_instr(input int core, input logic [16:0] pc, input logic [16:0] a,
                           input logic [16:0] b, input logic [31:0] d,
                           input logic [16:0] npc, input int stall);
    logic [16:0] ea [4];
    logic [16:0] eb [4];
    logic [16:0] oa, ob;
    logic        ow;
    logic [31:0] od;
    logic [1:0]  ost;
    ea[0] = pc;          eb[0] = pc + 17'd1;
    ea[1] = pc + 17'd2;  eb[1] = pc + 17'd1;
    ea[2] = a;           eb[2] = b;
    ea[3] = a;           eb[3] = b;
    for (int ph = 0; ph < 4; ph++) begin
      for (int s = 0; s <= stall; s++) begin
        oa  = (core == 0) ? a0 : a1;
        ob  = (core == 0) ? b0 : b1;
        ow  = (core == 0) ? we0 : we1;
        od  = (core == 0) ? wd0 : wd1;
        ost = (core == 0) ? u0.state : u1.state;
        tests++;
        if (oa !== ea[ph] || ob !== eb[ph] || ow !== (ph == 3) || ost !== 2'(ph) ||
            (ph == 3 && od !== d)) begin
          fails++;
          $display("FAIL instr core%0d pc=%h ph%0d s%0d: got a=%h b=%h we=%b st=%0d d=%h, want a=%h b=%h we=%b st=%0d d=%h",
                   core, pc, ph, s, oa, ob, ow, ost, od, ea[ph], eb[ph], (ph == 3), ph, d);
        end
        if (s == stall) do_cycle(core == 0, core == 1);
        else do_cycle(1'b0, 1'b0);
      end
    end
    oa  = (core == 0) ? a0 : a1;
    ost = (core == 0) ? u0.state : u1.state;
    tests++;
    if (oa !== npc || ost !== 2'd0) begin
      fails++;
      $display("FAIL next_pc core%0d: got a=%h st=%0d, want a=%h st=0", core, oa, ost, npc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    do_cycle(1'b0, 1'b0);
    tests++;
    if (u0.state !== 2'd0 || a0 !== 17'h00000 || b0 !== 17'h00001 || we0 !== 1'b0 || wd0 !== 32'd0) begin
      fails++;
      $display("FAIL reset_core0: got st=%0d a=%h b=%h we=%b d=%h, want 0 00000 00001 0 0", u0.state, a0, b0, we0, wd0);
    end
    tests++;
    if (u1.state !== 2'd0 || a1 !== 17'h10000 || b1 !== 17'h10001 || we1 !== 1'b0 || wd1 !== 32'd0) begin
      fails++;
      $display("FAIL reset_core1: got st=%0d a=%h b=%h we=%b d=%h, want 0 10000 10001 0 0", u1.state, a1, b1, we1, wd1);
    end
    do_cycle(1'b1, 1'b0);
    tests++;
    if (u0.state !== 2'd0 || a0 !== 17'h00000) begin
      fails++;
      $display("FAIL reset_priority: got st=%0d a=%h, want st=0 a=00000", u0.state, a0);
    end
    reset = 1'b0;
  endtask

  task automatic test_no_branch();
    mem[0] = 32'd3; mem[1] = 32'hABCC_0004; mem[2] = 32'd0;
    mem[3] = 32'd5; mem[4] = 32'd7;
    do_reset();
    exp_instr(0, 17'h00000, 17'd3, 17'd4, 32'd2, 17'h00003, 0);
    tests++;
    if (mem[4] !== 32'd2) begin
      fails++;
      $display("FAIL no_branch_mem: got M[4]=%h, want 00000002", mem[4]);
    end
  endtask

  task automatic test_branch();
    mem[0] = 32'd3; mem[1] = 32'd4; mem[2] = 32'd0;
    mem[3] = 32'd7; mem[4] = 32'd5;
    do_reset();
    exp_instr(0, 17'h00000, 17'd3, 17'd4, 32'hFFFF_FFFE, 17'h00000, 0);
    tests++;
    if (mem[4] !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL neg_branch_mem: got M[4]=%h, want fffffffe", mem[4]);
    end
    mem[0] = 32'd3; mem[1] = 32'd4; mem[2] = 32'd9;
    mem[3] = 32'd6; mem[4] = 32'd6;
    do_reset();
    exp_instr(0, 17'h00000, 17'd3, 17'd4, 32'd0, 17'h00009, 0);
    tests++;
    if (mem[4] !== 32'd0) begin
      fails++;
      $display("FAIL zero_branch_mem: got M[4]=%h, want 00000000", mem[4]);
    end
  endtask

  task automatic test_stall();
    for (int st = 1; st <= 3; st += 2) begin
      mem[0] = 32'd3; mem[1] = 32'd4; mem[2] = 32'd0;
      mem[3] = 32'd5; mem[4] = 32'd7;
      do_reset();
      exp_instr(0, 17'h00000, 17'd3, 17'd4, 32'd2, 17'h00003, st);
      tests++;
      if (mem[4] !== 32'd2) begin
        fails++;
        $display("FAIL stall%0d_mem: got M[4]=%h, want 00000002", st, mem[4]);
      end
    end
  endtask

  task automatic test_two_cores();
    logic [16:0] ea0 [4];
    logic [16:0] eb0 [4];
    logic [16:0] ea1 [4];
    logic [16:0] eb1 [4];
    int          c, ph;
    logic        ok;
    ea0 = '{17'h00000, 17'h00002, 17'h00003, 17'h00003};
    eb0 = '{17'h00001, 17'h00001, 17'h00004, 17'h00004};
    ea1 = '{17'h10000, 17'h10002, 17'h10003, 17'h10003};
    eb1 = '{17'h10001, 17'h10001, 17'h10004, 17'h10004};
    mem[0] = 32'd3; mem[1] = 32'd4; mem[2] = 32'd0;
    mem[3] = 32'd5; mem[4] = 32'd7;
    mem[17'h10000] = 32'h0001_0003; mem[17'h10001] = 32'h0001_0004; mem[17'h10002] = 32'h0001_0000;
    mem[17'h10003] = 32'd9; mem[17'h10004] = 32'd4;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      c  = i % 2;
      ph = i / 2;
      if (c == 0) ok = (a0 === ea0[ph]) && (b0 === eb0[ph]) && (we0 === (ph == 3)) && (ph != 3 || wd0 === 32'd2);
      else        ok = (a1 === ea1[ph]) && (b1 === eb1[ph]) && (we1 === (ph == 3)) && (ph != 3 || wd1 === 32'hFFFF_FFFB);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL two_cores core%0d ph%0d: got a=%h b=%h we=%b d=%h, want a=%h b=%h we=%b",
                 c, ph, (c == 0) ? a0 : a1, (c == 0) ? b0 : b1, (c == 0) ? we0 : we1,
                 (c == 0) ? wd0 : wd1, (c == 0) ? ea0[ph] : ea1[ph], (c == 0) ? eb0[ph] : eb1[ph], (ph == 3));
      end
      do_cycle(c == 0, c == 1);
    end
    tests++;
    if (a0 !== 17'h00003 || a1 !== 17'h10000 || mem[4] !== 32'd2 || mem[17'h10004] !== 32'hFFFF_FFFB) begin
      fails++;
      $display("FAIL two_cores_end: got a0=%h a1=%h M4=%h M10004=%h, want 00003 10000 00000002 fffffffb",
               a0, a1, mem[4], mem[17'h10004]);
    end
  endtask

  task automatic test_reset_mid();
    mem[0] = 32'd3; mem[1] = 32'd4; mem[2] = 32'd0;
    mem[3] = 32'd5; mem[4] = 32'd7;
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0);
    tests++;
    if (u0.state !== 2'd3 || we0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: got st=%0d we=%b, want st=3 we=1", u0.state, we0);
    end
    reset = 1'b1;
    do_cycle(1'b0, 1'b0);
    reset = 1'b0;
    tests++;
    if (we0 !== 1'b0 || u0.state !== 2'd0 || a0 !== 17'h00000 || b0 !== 17'h00001 || mem[4] !== 32'd7) begin
      fails++;
      $display("FAIL reset_mid: got we=%b st=%0d a=%h b=%h M4=%h, want 0 0 00000 00001 00000007",
               we0, u0.state, a0, b0, mem[4]);
    end
  endtask

  task automatic test_wrap();
    mem[0] = 32'd3; mem[1] = 32'd4; mem[2] = 32'h0001_FFFE;
    mem[3] = 32'd1; mem[4] = 32'd1;
    mem[17'h1FFFE] = 32'd5; mem[17'h1FFFF] = 32'd6;
    mem[5] = 32'd1; mem[6] = 32'd10;
    do_reset();
    exp_instr(0, 17'h00000, 17'd3, 17'd4, 32'd0, 17'h1FFFE, 0);
    exp_instr(0, 17'h1FFFE, 17'd5, 17'd6, 32'd9, 17'h00001, 0);
    tests++;
    if (mem[6] !== 32'd9) begin
      fails++;
      $display("FAIL wrap_mem: got M[6]=%h, want 00000009", mem[6]);
    end
  endtask

  initial begin
    reset = 1'b1;
    en0   = 1'b0;
    en1   = 1'b0;
    for (int i = 0; i < 131072; i++) mem[i] = 32'd0;
    @(posedge clock);
    #1;
    test_reset();
    test_no_branch();
    test_branch();
    test_stall();
    test_two_cores();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
